proc_launcher: RTL and testbench

- Host-side sequencer on the other end of the control unit's status/end_process handshake.
- Accepts a start request from the host interface and drives the 2-bit status code that moves the control unit out of its idle state.
- Waits for end_process and measures execution cycles.
- Reports done or timeout back to the host.

---
 rtl/proc_pkg.sv | 35 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/proc_launcher.sv | 165 ++++++++++++++++
 tb/tb_proc_launcher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the process launcher: control-unit status codes,
// launcher FSM encoding and default counter width.
package proc_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int HOLD_W    = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FIN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_TMO   = 3'd4
  } lstate_e;

  // Status code the control unit sees while the launcher sits in a state.
  function automatic logic [1:0] status_of(input lstate_e s);
    logic [1:0] code;
    case (s)
      S_IDLE:  code = ST_IDLE;
      S_START: code = ST_START;
      S_RUN:   code = ST_RUN;
      S_DONE:  code = ST_FIN;
      S_TMO:   code = ST_FIN;
      default: code = ST_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over enable, no wrap past all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_launcher.sv
// Host-side sequencer driving the control unit's status/end_process handshake.
// Optional watchdog enabled by defining PROC_LAUNCHER_WDOG_EN.
module proc_launcher
  import proc_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  output logic             start_ack,
  output logic             start_err,
  input  logic             end_process,
  output logic [1:0]       status,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 15) || (TIMEOUT_CYCLES < 1)) begin : g_param_chk
    $error("proc_launcher: HOLD_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  lstate_e          state_q, state_d;
  logic             end_prev_q;
  logic             start_ack_q, start_ack_d;
  logic             start_err_q, start_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       status_q, status_d;

  logic [CNT_W-1:0]  cycle_cnt_s;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              cnt_clr_s, cnt_en_s;
  logic              hold_clr_s, hold_en_s;
  logic              rise_s;
  logic              wdog_hit_s;

  assign rise_s = end_process & ~end_prev_q;

`ifdef PROC_LAUNCHER_WDOG_EN
  // A limit above the counter's saturation value can never be reached.
  localparam bit              TMO_REACH = (64'(TIMEOUT_CYCLES) <= ((64'd1 << CNT_W) - 64'd1));
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  assign wdog_hit_s = TMO_REACH && (cycle_cnt_s >= TMO_LIM);
`else
  assign wdog_hit_s = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .cnt_o (cycle_cnt_s)
  );

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (hold_clr_s),
    .en_i  (hold_en_s),
    .cnt_o (hold_cnt_s)
  );

  // Next state, counter controls and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    start_ack_d = 1'b0;
    start_err_d = 1'b0;
    timeout_d   = timeout_q;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    hold_clr_s  = 1'b0;
    hold_en_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The ack guard keeps a still-high request from being acked twice.
        if (start_req && !start_ack_q) begin
          start_ack_d = 1'b1;
          if (end_process) begin
            start_err_d = 1'b1;
          end else begin
            state_d    = S_START;
            cnt_clr_s  = 1'b1;
            hold_clr_s = 1'b1;
            timeout_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rise_s) begin
          state_d = S_DONE;
        end else begin
          cnt_en_s  = 1'b1;
          hold_en_s = 1'b1;
          if (hold_cnt_s == HOLD_LAST) begin
            state_d = S_RUN;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_RUN: begin
        // A completion in the same cycle as watchdog expiry counts as done.
        if (rise_s) begin
          state_d = S_DONE;
        end else if (wdog_hit_s) begin
          state_d   = S_TMO;
          timeout_d = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_TMO:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    status_d = status_of(state_d);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      end_prev_q  <= 1'b0;
      start_ack_q <= 1'b0;
      start_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      status_q    <= ST_IDLE;
    end else begin
      state_q     <= state_d;
      end_prev_q  <= end_process;
      start_ack_q <= start_ack_d;
      start_err_q <= start_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      status_q    <= status_d;
    end
  end

  assign start_ack   = start_ack_q;
  assign start_err   = start_err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign status      = status_q;
  assign cycle_count = cycle_cnt_s;

endmodule

// File: tb/tb_proc_launcher.sv
// Randomized scoreboard bench for proc_launcher; expected events are derived
// from the run length the stimulus chooses and checked by a separate monitor.
module tb_proc_launcher;

  localparam int CNT_W   = 6;
  localparam int HOLD    = 2;
  localparam int TMO_C   = 20;
  localparam int MAXC    = (1 << CNT_W) - 1;

  localparam int EV_ACK  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TMO  = 2;

  typedef struct {
    int kind;
    int err;
    int cnt;
    int hold;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_req = 1'b0;
  logic             end_process = 1'b0;
  logic             start_ack, start_err, busy, done, timeout;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   hold_cnt = 0;
  bit   exp_tflag = 1'b0;
  bit   idle_next = 1'b0;

  proc_launcher #(
    .CNT_W          (CNT_W),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_req   (start_req),
    .start_ack   (start_ack),
    .start_err   (start_err),
    .end_process (end_process),
    .status      (status),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endfunction

  // Reference: a run whose end_process rise is seen k cycles after START entry.
  function automatic void push_run(input int k);
    exp_t e;
    e = '{kind: EV_ACK, err: 0, cnt: 0, hold: 0};
    sb.push_back(e);
`ifdef PROC_LAUNCHER_WDOG_EN
    if ((TMO_C <= MAXC) && (k > TMO_C)) begin
      e = '{kind: EV_TMO, err: 0, cnt: TMO_C, hold: HOLD};
      sb.push_back(e);
      return;
    end
`endif
    e = '{kind: EV_DONE, err: 0, cnt: (k < MAXC) ? k : MAXC, hold: (k + 1 < HOLD) ? k + 1 : HOLD};
    sb.push_back(e);
  endfunction

  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (start_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ack_within_bound", seen, 1'b1);
  endtask

  task automatic do_run(input int k);
    end_process = 1'b0;
    push_run(k);
    start_req = 1'b1;
    wait_ack();
    start_req = 1'b0;
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
    end_process = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    chk("run_ends_within_bound", busy, 1'b0);
  endtask

  task automatic do_reject();
    exp_t e;
    end_process = 1'b1;
    e = '{kind: EV_ACK, err: 1, cnt: 0, hold: 0};
    sb.push_back(e);
    start_req = 1'b1;
    wait_ack();
    start_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack, done or timeout.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_tflag = 1'b0;
        idle_next = 1'b0;
        hold_cnt  = 0;
      end else begin
        if (idle_next) begin
          chk("status_idle_after_end", status, 2'b00);
          chk("busy_low_after_end", busy, 1'b0);
          idle_next = 1'b0;
        end
        if (start_err && !start_ack) fail("err_without_ack");
        if (start_ack) begin
          if (sb.size() == 0) begin
            fail("unexpected_ack");
          end else begin
            e = sb.pop_front();
            chk("ack_kind", EV_ACK, e.kind);
            chk("ack_err", start_err, e.err);
            if (e.err != 0) begin
              chk("reject_status", status, 2'b00);
              chk("reject_busy", busy, 1'b0);
              chk("reject_timeout_kept", timeout, exp_tflag);
            end else begin
              chk("accept_status", status, 2'b01);
              chk("accept_busy", busy, 1'b1);
              chk("accept_count_clr", cycle_count, 0);
              chk("accept_timeout_clr", timeout, 1'b0);
              exp_tflag = 1'b0;
              hold_cnt  = 0;
            end
          end
        end
        if (status == 2'b01) hold_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            fail("unexpected_done");
          end else begin
            e = sb.pop_front();
            chk("done_kind", EV_DONE, e.kind);
            chk("done_count", cycle_count, e.cnt);
            chk("done_hold_cycles", hold_cnt, e.hold);
            chk("done_status", status, 2'b11);
            chk("done_busy", busy, 1'b1);
            idle_next = 1'b1;
          end
        end else if (status == 2'b11) begin
          if (sb.size() == 0) begin
            fail("unexpected_tmo");
          end else begin
            e = sb.pop_front();
            chk("tmo_kind", EV_TMO, e.kind);
            chk("tmo_count", cycle_count, e.cnt);
            chk("tmo_flag", timeout, 1'b1);
            exp_tflag = 1'b1;
            idle_next = 1'b1;
          end
        end
      end
    end
  end

  // Stimulus: directed cases, randomized runs, then a mid-run reset.
  initial begin
    int k;
    #12;
    chk("rst_status", status, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", start_ack, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_count", cycle_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_run(50);
    do_reject();
    do_run(1);
    do_run(0);
    do_run(80);
    do_run(TMO_C);
    do_run(TMO_C + 1);
    do_reject();
    do_run(3);

    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 90);
      do_run(k);
      if ($urandom_range(0, 2) == 0) do_reject();
      end_process = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    end_process = 1'b0;
    push_run(60);
    start_req = 1'b1;
    wait_ack();
    start_req = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_status", status, 2'b00);
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_count", cycle_count, 0);
    chk("midrun_rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    end_process = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", status, 2'b00);
    do_run(7);

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

endmodule
